// File: rtl/trap_pkg.sv
// Shared types and constants for the commit-stage trap sequencer.
package trap_pkg;

    typedef enum logic [2:0] {
        K_NORMAL = 3'd0,
        K_CSR    = 3'd1,
        K_MRET   = 3'd2,
        K_SRET   = 3'd3,
        K_URET   = 3'd4,
        K_WFI    = 3'd5
    } kind_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CSR   = 3'd1,
        S_TRAP  = 3'd2,
        S_RET   = 3'd3,
        S_WFI   = 3'd4,
        S_DRAIN = 3'd5
    } state_e;

    localparam logic [63:0] CAUSE_ILLEGAL = 64'd2;
    localparam logic [2:0]  RET_M         = 3'b111;
    localparam logic [2:0]  RET_S         = 3'b101;

    // Interrupt causes carry the interrupt flag in the MSB.
    function automatic logic [63:0] irq_cause(input logic [5:0] code);
        return {1'b1, 57'd0, code};
    endfunction

endpackage

// File: rtl/trap_seq.sv
// Commit-stage sequencer: retire, CSR access, trap, xRET and WFI handling,
// followed by the fetch redirect / pipeline flush drain.
module trap_seq
    import trap_pkg::*;
#(
    parameter int unsigned FLUSH_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        head_vld,
    input  logic [63:0] head_pc,
    input  logic [2:0]  head_kind,
    input  logic        head_exc,
    input  logic [63:0] head_cause,
    input  logic [63:0] head_tval,
    output logic        head_ack,
    output logic        busy,
    output logic        csr_rqst,
    output logic        csr_ein,
    output logic [63:0] csr_epc,
    output logic [63:0] csr_cause,
    output logic [63:0] csr_tval,
    output logic [2:0]  csr_ret,
    input  logic        csr_eout,
    input  logic        csr_flush,
    input  logic        csr_intl,
    input  logic [6:0]  csr_intg,
    input  logic [63:0] csr_tvec,
    input  logic [63:0] csr_mepc,
    input  logic [63:0] csr_sepc,
    output logic        redir,
    output logic [63:0] redir_pc,
    output logic        flush
);

    localparam int unsigned CNT_W = (FLUSH_LAT > 1) ? $clog2(FLUSH_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_LAT - 1);

    state_e             state;
    logic [63:0]        epc;
    logic [63:0]        cause;
    logic [63:0]        tval;
    logic [63:0]        target;
    logic [63:0]        pc_wfi;
    logic               ret_m;
    logic [CNT_W-1:0]   cnt;

    // State and trap/redirect context.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            epc    <= '0;
            cause  <= '0;
            tval   <= '0;
            target <= '0;
            pc_wfi <= '0;
            ret_m  <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (head_vld) begin
                        epc  <= head_pc;
                        tval <= '0;
                        if (csr_intg[6]) begin
                            cause <= irq_cause(csr_intg[5:0]);
                            state <= S_TRAP;
                        end else if (head_exc) begin
                            cause <= head_cause;
                            tval  <= head_tval;
                            state <= S_TRAP;
                        end else begin
                            case (kind_e'(head_kind))
                                K_NORMAL: state <= S_IDLE;
                                K_CSR:    state <= S_CSR;
                                K_MRET, K_SRET: begin
                                    ret_m <= (head_kind == 3'(K_MRET));
                                    state <= S_RET;
                                end
                                K_WFI: begin
                                    pc_wfi <= head_pc + 64'd4;
                                    state  <= S_WFI;
                                end
                                // uret and the unused encodings are illegal
                                default: begin
                                    cause <= CAUSE_ILLEGAL;
                                    state <= S_TRAP;
                                end
                            endcase
                        end
                    end
                end
                S_CSR: begin
                    if (csr_eout) begin
                        cause <= CAUSE_ILLEGAL;
                        tval  <= '0;
                        state <= S_TRAP;
                    end else if (csr_flush) begin
                        target <= epc + 64'd4;
                        state  <= S_DRAIN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_TRAP: begin
                    target <= csr_tvec;
                    state  <= S_DRAIN;
                end
                S_RET: begin
                    target <= ret_m ? csr_mepc : csr_sepc;
                    state  <= S_DRAIN;
                end
                S_WFI: begin
                    if (csr_intl) begin
                        if (csr_intg[6]) begin
                            epc   <= pc_wfi;
                            cause <= irq_cause(csr_intg[5:0]);
                            tval  <= '0;
                            state <= S_TRAP;
                        end else begin
                            target <= pc_wfi;
                            state  <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output decode; reset forces every output low in the same cycle.
    always_comb begin
        head_ack  = 1'b0;
        busy      = 1'b0;
        csr_rqst  = 1'b0;
        csr_ein   = 1'b0;
        csr_epc   = '0;
        csr_cause = '0;
        csr_tval  = '0;
        csr_ret   = '0;
        redir     = 1'b0;
        redir_pc  = '0;
        flush     = 1'b0;
        if (!rst) begin
            busy      = (state != S_IDLE);
            csr_epc   = epc;
            csr_cause = cause;
            csr_tval  = tval;
            unique case (state)
                S_IDLE: head_ack = head_vld && !csr_intg[6] && !head_exc &&
                                   (head_kind == 3'(K_NORMAL) || head_kind == 3'(K_WFI));
                S_CSR: begin
                    csr_rqst = 1'b1;
                    head_ack = !csr_eout;
                end
                S_TRAP: csr_ein = 1'b1;
                S_RET: begin
                    csr_ret  = ret_m ? RET_M : RET_S;
                    head_ack = 1'b1;
                end
                S_DRAIN: begin
                    flush    = 1'b1;
                    redir    = 1'b1;
                    redir_pc = target;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_seq.sv
// Scoreboard bench for trap_seq: expected per-cycle events are queued from a
// transaction-level model and matched by an independent monitor.
module tb_trap_seq;
    import trap_pkg::*;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        head_vld = 1'b0;
    logic [63:0] head_pc = '0;
    logic [2:0]  head_kind = '0;
    logic        head_exc = 1'b0;
    logic [63:0] head_cause = '0;
    logic [63:0] head_tval = '0;
    logic        head_ack, busy, csr_rqst, csr_ein, redir, flush;
    logic [63:0] csr_epc, csr_cause, csr_tval, redir_pc;
    logic [2:0]  csr_ret;
    logic        csr_eout = 1'b0;
    logic        csr_flush = 1'b0;
    logic        csr_intl = 1'b0;
    logic [6:0]  csr_intg = '0;
    logic [63:0] csr_tvec = '0;
    logic [63:0] csr_mepc = '0;
    logic [63:0] csr_sepc = '0;

    always #5 clk = ~clk;

    trap_seq #(.FLUSH_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .head_vld(head_vld), .head_pc(head_pc), .head_kind(head_kind),
        .head_exc(head_exc), .head_cause(head_cause), .head_tval(head_tval),
        .head_ack(head_ack), .busy(busy),
        .csr_rqst(csr_rqst), .csr_ein(csr_ein), .csr_epc(csr_epc),
        .csr_cause(csr_cause), .csr_tval(csr_tval), .csr_ret(csr_ret),
        .csr_eout(csr_eout), .csr_flush(csr_flush), .csr_intl(csr_intl),
        .csr_intg(csr_intg), .csr_tvec(csr_tvec), .csr_mepc(csr_mepc),
        .csr_sepc(csr_sepc),
        .redir(redir), .redir_pc(redir_pc), .flush(flush)
    );

    typedef enum int {EV_RQST, EV_EIN, EV_RET, EV_ACK, EV_REDIR} ev_e;
    typedef struct {
        ev_e         ev;
        int          cyc;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input ev_e e, input int c, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] cc);
        item_t it;
        it.ev = e; it.cyc = c; it.a = a; it.b = b; it.c = cc;
        q.push_back(it);
    endfunction

    function automatic void push_redirs(input int start, input logic [63:0] pc);
        for (int i = 0; i < int'(LAT); i++) push(EV_REDIR, start + i, pc, 64'd0, 64'd0);
    endfunction

    function automatic logic [63:0] icause(input logic [5:0] code);
        logic [63:0] v;
        v = 64'(code);
        v[63] = 1'b1;
        return v;
    endfunction

    task automatic pop_chk(input ev_e e, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c);
        item_t it;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: DUT event at cycle %0d, expected none", e.name(), cyc);
            return;
        end
        it = q.pop_front();
        chk({e.name(), "_order"}, 64'(e), 64'(it.ev));
        chk({e.name(), "_cycle"}, 64'(cyc), 64'(it.cyc));
        if (e == EV_EIN || e == EV_RET || e == EV_REDIR) chk({e.name(), "_val"}, a, it.a);
        if (e == EV_EIN) begin
            chk("EIN_cause", b, it.b);
            chk("EIN_tval", c, it.c);
        end
    endtask

    // Monitor: match every DUT strobe against the scoreboard queue.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("excl", 64'((csr_rqst & csr_ein) | (csr_rqst & csr_ret[2]) | (csr_ein & csr_ret[2])), 64'd0);
            if (csr_rqst)   pop_chk(EV_RQST, 64'd0, 64'd0, 64'd0);
            if (csr_ein)    pop_chk(EV_EIN, csr_epc, csr_cause, csr_tval);
            if (csr_ret[2]) pop_chk(EV_RET, 64'(csr_ret), 64'd0, 64'd0);
            if (head_ack)   pop_chk(EV_ACK, 64'd0, 64'd0, 64'd0);
            if (redir) begin
                pop_chk(EV_REDIR, redir_pc, 64'd0, 64'd0);
                chk("flush_on", 64'(flush), 64'd1);
            end else if (flush) begin
                chk("flush_off", 64'(flush), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One head instruction: drive it, queue the spec-derived event timeline, wait for IDLE.
    task automatic do_txn(input logic [2:0] kind, input logic exc, input logic [63:0] pc,
                          input logic [63:0] cause, input logic [63:0] tval,
                          input logic [6:0] intg, input logic eout, input logic fl,
                          input logic [63:0] tvec, input logic [63:0] mepc,
                          input logic [63:0] sepc, input int dly, input logic [6:0] wintg);
        int  d;
        int  w;
        bit  is_wfi;
        head_vld = 1'b1; head_kind = kind; head_exc = exc; head_pc = pc;
        head_cause = cause; head_tval = tval;
        csr_intg = intg; csr_eout = eout; csr_flush = fl; csr_intl = 1'b0;
        csr_tvec = tvec; csr_mepc = mepc; csr_sepc = sepc;
        d = cyc;
        is_wfi = 1'b0;
        if (intg[6]) begin
            push(EV_EIN, d + 1, pc, icause(intg[5:0]), 64'd0);
            push_redirs(d + 2, tvec);
        end else if (exc) begin
            push(EV_EIN, d + 1, pc, cause, tval);
            push_redirs(d + 2, tvec);
        end else begin
            case (kind)
                3'd0: push(EV_ACK, d, 64'd0, 64'd0, 64'd0);
                3'd1: begin
                    push(EV_RQST, d + 1, 64'd0, 64'd0, 64'd0);
                    if (eout) begin
                        push(EV_EIN, d + 2, pc, 64'd2, 64'd0);
                        push_redirs(d + 3, tvec);
                    end else begin
                        push(EV_ACK, d + 1, 64'd0, 64'd0, 64'd0);
                        if (fl) push_redirs(d + 2, pc + 64'd4);
                    end
                end
                3'd2, 3'd3: begin
                    push(EV_RET, d + 1, (kind == 3'd2) ? 64'd7 : 64'd5, 64'd0, 64'd0);
                    push(EV_ACK, d + 1, 64'd0, 64'd0, 64'd0);
                    push_redirs(d + 2, (kind == 3'd2) ? mepc : sepc);
                end
                3'd5: begin
                    push(EV_ACK, d, 64'd0, 64'd0, 64'd0);
                    is_wfi = 1'b1;
                end
                default: begin
                    push(EV_EIN, d + 1, pc, 64'd2, 64'd0);
                    push_redirs(d + 2, tvec);
                end
            endcase
        end
        step();
        head_vld = 1'b0;
        head_exc = 1'b0;
        if (is_wfi) begin
            csr_intg = '0;
            for (int i = 1; i < dly; i++) begin
                chk("wfi_busy", 64'(busy), 64'd1);
                step();
            end
            csr_intl = 1'b1;
            csr_intg = wintg;
            w = cyc;
            if (wintg[6]) begin
                push(EV_EIN, w + 1, pc + 64'd4, icause(wintg[5:0]), 64'd0);
                push_redirs(w + 2, tvec);
            end else begin
                push_redirs(w + 1, pc + 64'd4);
            end
            step();
            csr_intl = 1'b0;
            csr_intg = '0;
        end
        for (int i = 0; i < 40 && busy; i++) step();
        chk("return_idle", 64'(busy), 64'd0);
        csr_intg = '0; csr_eout = 1'b0; csr_flush = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        // Reset with a retirable head present: nothing may leak out.
        head_vld = 1'b1;
        head_kind = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 64'({head_ack, busy, csr_rqst, csr_ein, csr_ret, redir, flush}), 64'd0);
        @(posedge clk);
        #1;
        head_vld = 1'b0;
        rst = 1'b0;

        // Reset in the middle of DRAIN.
        head_vld = 1'b1; head_exc = 1'b1; head_pc = 64'h8000_0020;
        head_cause = 64'd13; head_tval = 64'h55; csr_tvec = 64'h8000_0100;
        step();
        head_vld = 1'b0; head_exc = 1'b0;
        step();
        @(negedge clk);
        chk("pre_rst_redir", 64'(redir), 64'd1);
        chk("pre_rst_pc", redir_pc, 64'h8000_0100);
        rst = 1'b1;
        #1;
        chk("rst_drain_ctrl", 64'({head_ack, busy, csr_rqst, csr_ein, csr_ret, redir, flush}), 64'd0);
        chk("rst_drain_data", csr_epc | csr_cause | csr_tval | redir_pc, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_redir", 64'(redir), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Directed scenarios.
        do_txn(3'd1, 1'b0, 64'h8000_0010, 64'd0, 64'd0, 7'h00, 1'b0, 1'b1,
               64'h8000_0100, 64'd0, 64'd0, 1, 7'h00);
        do_txn(3'd1, 1'b0, 64'h8000_0018, 64'd0, 64'd0, 7'h00, 1'b1, 1'b0,
               64'h8000_0100, 64'd0, 64'd0, 1, 7'h00);
        do_txn(3'd0, 1'b1, 64'h8000_0030, 64'd13, 64'h99, 7'h47, 1'b0, 1'b0,
               64'h8000_0100, 64'd0, 64'd0, 1, 7'h00);
        do_txn(3'd2, 1'b0, 64'h8000_0034, 64'd0, 64'd0, 7'h00, 1'b0, 1'b0,
               64'h8000_0100, 64'h8000_2000, 64'h8000_3000, 1, 7'h00);
        do_txn(3'd5, 1'b0, 64'h8000_0040, 64'd0, 64'd0, 7'h00, 1'b0, 1'b0,
               64'h8000_0100, 64'd0, 64'd0, 5, 7'h00);
        do_txn(3'd5, 1'b0, 64'h8000_0040, 64'd0, 64'd0, 7'h00, 1'b0, 1'b0,
               64'h8000_0100, 64'd0, 64'd0, 5, 7'h45);
        do_txn(3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 7'h00, 1'b0, 1'b0,
               64'h8000_0100, 64'd0, 64'd0, 2, 7'h00);
        do_txn(3'd4, 1'b0, 64'h8000_0050, 64'd0, 64'd0, 7'h00, 1'b0, 1'b0,
               64'h8000_0200, 64'd0, 64'd0, 1, 7'h00);
        do_txn(3'd3, 1'b0, 64'h8000_0054, 64'd0, 64'd0, 7'h00, 1'b0, 1'b0,
               64'h8000_0100, 64'h8000_2000, 64'h8000_3000, 1, 7'h00);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            logic [6:0]  intg;
            logic [6:0]  wintg;
            logic [63:0] pc;
            intg  = 7'($urandom());
            intg[6] = ($urandom_range(0, 5) == 0);
            wintg = 7'($urandom());
            pc    = rnd64() & ~64'd3;
            if ($urandom_range(0, 9) == 0) pc = 64'hFFFF_FFFF_FFFF_FFF0 | (pc & 64'hC);
            do_txn(3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0), pc,
                   rnd64(), rnd64(), intg, ($urandom_range(0, 3) == 0), 1'($urandom()),
                   rnd64(), rnd64(), rnd64(), $urandom_range(1, 6), wintg);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (5) step();
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
